atom_trace_gpio: RTL and testbench



---
 rtl/atom_trace_gpio_if.sv | 24 ++
 rtl/atom_trace_gpio.sv | 149 ++++++++++++++
 tb/tb_atom_trace_gpio.sv | 261 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/atom_trace_gpio_if.sv
// rtl/atom_trace_gpio_if.sv - CPU bus record interface feeding the trace serializer
interface atom_trace_gpio_if;
  logic        cpu_clken;
  logic [15:0] cpu_addr;
  logic [7:0]  cpu_data;
  logic        cpu_rnw;
  logic        cpu_sync;

  modport master (
    output cpu_clken,
    output cpu_addr,
    output cpu_data,
    output cpu_rnw,
    output cpu_sync
  );

  modport slave (
    input cpu_clken,
    input cpu_addr,
    input cpu_data,
    input cpu_rnw,
    input cpu_sync
  );
endinterface

// File: rtl/atom_trace_gpio.sv
// rtl/atom_trace_gpio.sv - 6502 bus-trace serializer streaming 11-bit words on the GPIO header
module atom_trace_gpio #(
  parameter int DIV        = 4,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                clock,
  input  logic                reset,
  input  logic                trace_en,
  atom_trace_gpio_if.slave    cpu,
  input  logic [13:0]         user_gpio,
  output logic [13:0]         gpio,
  output logic                overflow
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [10:0] IDLE_WORD = 11'h3FF;

  // Record layout: {addr[15:0], data[7:0], rnw, sync}
  localparam int RW = 26;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    W0   = 2'd1,
    W1   = 2'd2,
    W2   = 2'd3
  } state_t;

  // The strobe divider deliberately ignores reset so the capture device
  // keeps seeing a clean phi2 while the rest of the block is held.
  logic [CW-1:0] div_cnt = '0;
  logic          phi2    = 1'b0;
  logic          toggle;
  logic          rise_evt;

  assign toggle   = (div_cnt == CW'(DIV - 1));
  assign rise_evt = toggle && !phi2;

  // Free-running phi2 divider, toggles every DIV clocks
  always_ff @(posedge clock) begin
    if (toggle) begin
      div_cnt <= '0;
      phi2    <= ~phi2;
    end else begin
      div_cnt <= div_cnt + CW'(1);
    end
  end

  logic [RW-1:0] mem [FIFO_DEPTH];
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic          empty;
  logic          full;
  logic          capture;
  logic          push;
  logic          pop;
  logic          drop;
  logic [RW-1:0] head;
  logic [RW-1:0] rec_in;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign capture = cpu.cpu_clken && trace_en && !reset;
  // A pop in the same clock frees a slot, so a push into a full FIFO still lands.
  assign push    = capture && (!full || pop);
  assign drop    = capture && full && !pop;
  assign head    = mem[rd_ptr[AW-1:0]];
  assign rec_in  = {cpu.cpu_addr, cpu.cpu_data, cpu.cpu_rnw, cpu.cpu_sync};

  // FIFO pointers, flushed on reset and whenever tracing is off
  always_ff @(posedge clock) begin
    if (reset || !trace_en) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
    end
  end

  // FIFO storage write
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr[AW-1:0]] <= rec_in;
  end

  // Sticky drop flag
  always_ff @(posedge clock) begin
    if (reset || !trace_en) overflow <= 1'b0;
    else if (drop)          overflow <= 1'b1;
  end

  state_t        state;
  state_t        state_next;
  logic [10:0]   word;
  logic [10:0]   word_next;
  logic [15:0]   hold_addr;

  // Emitter state and word register, advanced only on phi2 rise so the word
  // is stable across the following falling edge
  always_ff @(posedge clock) begin
    if (reset || !trace_en) begin
      state <= IDLE;
      word  <= IDLE_WORD;
    end else if (rise_evt) begin
      state <= state_next;
      word  <= word_next;
    end
  end

  // Hold the popped address for the two address words that follow W0
  always_ff @(posedge clock) begin
    if (pop) hold_addr <= head[25:10];
  end

  // Next-state: IDLE/W2 start a record when one is waiting, W0->W1->W2 otherwise
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    state_next = empty ? IDLE : W0;
      W0:      state_next = W1;
      W1:      state_next = W2;
      W2:      state_next = empty ? IDLE : W0;
      default: state_next = IDLE;
    endcase
  end

  // Word to present at the next rise, plus the FIFO pop that goes with a W0
  always_comb begin
    pop       = 1'b0;
    word_next = IDLE_WORD;
    case (state)
      IDLE, W2: begin
        if (!empty) begin
          pop       = rise_evt && trace_en && !reset;
          word_next = {1'b1, head[0], head[1], head[9:2]};
        end
      end
      W0:      word_next = {1'b0, 2'b01, hold_addr[7:0]};
      W1:      word_next = {1'b0, 2'b10, hold_addr[15:8]};
      default: word_next = IDLE_WORD;
    endcase
  end

  assign gpio = {user_gpio[13:12],
                 trace_en ? word[10]  : user_gpio[11],
                 phi2,
                 trace_en ? word[9:0] : user_gpio[9:0]};

endmodule

// File: tb/tb_atom_trace_gpio.sv
// tb/tb_atom_trace_gpio.sv - randomized self-checking bench for atom_trace_gpio
module tb_atom_trace_gpio;
  localparam int DIV   = 4;
  localparam int DEPTH = 16;
  localparam logic [10:0] IDLE_W = 11'h3FF;

  logic        clock = 1'b0;
  logic        reset;
  logic        trace_en;
  logic [13:0] user_gpio;
  logic [13:0] gpio;
  logic        overflow;

  atom_trace_gpio_if bus();

  atom_trace_gpio #(.DIV(DIV), .FIFO_DEPTH(DEPTH)) dut (
    .clock     (clock),
    .reset     (reset),
    .trace_en  (trace_en),
    .cpu       (bus.slave),
    .user_gpio (user_gpio),
    .gpio      (gpio),
    .overflow  (overflow)
  );

  always #5 clock = ~clock;

  int          n_checks = 0;
  int          n_fail   = 0;
  int          cyc      = 0;
  logic [10:0] cap_q[$];
  int          fall_cyc[$];
  logic [10:0] exp_q[$];

  initial forever begin
    @(posedge clock);
    cyc++;
  end

  // Capture device: samples gpio[11] and gpio[9:0] at each phi2 fall
  initial begin : monitor
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clock);
      if (prev && !gpio[10]) begin
        cap_q.push_back({gpio[11], gpio[9:0]});
        fall_cyc.push_back(cyc);
      end
      prev = gpio[10];
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic wait_falls(input int n);
    int target;
    int budget;
    target = cap_q.size() + n;
    budget = n * 2 * DIV + 4 * DIV + 20;
    while (cap_q.size() < target && budget > 0) begin
      @(negedge clock);
      budget--;
    end
    if (cap_q.size() < target) check_eq("fall_timeout", cap_q.size(), target);
  endtask

  task automatic expect_rec(input logic [15:0] a, input logic [7:0] d, input logic r, input logic s);
    exp_q.push_back({1'b1, s, r, d});
    exp_q.push_back({1'b0, 2'b01, a[7:0]});
    exp_q.push_back({1'b0, 2'b10, a[15:8]});
  endtask

  task automatic push_rec(input logic [15:0] a, input logic [7:0] d, input logic r, input logic s);
    bus.cpu_addr  = a;
    bus.cpu_data  = d;
    bus.cpu_rnw   = r;
    bus.cpu_sync  = s;
    bus.cpu_clken = 1'b1;
    @(negedge clock);
    bus.cpu_clken = 1'b0;
  endtask

  task automatic rand_rec(input logic expected);
    logic [15:0] a;
    logic [7:0]  d;
    logic        r;
    logic        s;
    a = 16'($urandom);
    d = 8'($urandom);
    r = 1'($urandom);
    s = 1'($urandom);
    if (expected) expect_rec(a, d, r, s);
    push_rec(a, d, r, s);
  endtask

  // Skip leading idle words, then the expected words must follow contiguously and be followed by idle
  task automatic check_stream(input string tag);
    int i;
    i = 0;
    while (i < cap_q.size() && cap_q[i] == IDLE_W) i++;
    check_eq({tag, "_len"}, 32'(cap_q.size() - i >= exp_q.size() + 1), 32'd1);
    for (int k = 0; k < exp_q.size(); k++)
      if (i + k < cap_q.size()) check_eq({tag, "_word"}, cap_q[i + k], exp_q[k]);
    if (i + exp_q.size() < cap_q.size())
      check_eq({tag, "_tail"}, cap_q[i + exp_q.size()], IDLE_W);
  endtask

  task automatic check_all_idle(input string tag);
    for (int k = 0; k < cap_q.size(); k++) check_eq(tag, cap_q[k], IDLE_W);
  endtask

  task automatic check_passthru(input string tag);
    check_eq({tag, "_hi"}, gpio[13:11], user_gpio[13:11]);
    check_eq({tag, "_lo"}, gpio[9:0], user_gpio[9:0]);
  endtask

  initial begin
    int   budget;
    int   toggles;
    logic prev_phi;
    logic seen;

    reset         = 1'b1;
    trace_en      = 1'b1;
    user_gpio     = 14'h0;
    bus.cpu_clken = 1'b0;
    bus.cpu_addr  = 16'h0;
    bus.cpu_data  = 8'h0;
    bus.cpu_rnw   = 1'b0;
    bus.cpu_sync  = 1'b0;

    // Reset held: phi2 keeps running, words stay idle, nothing is captured
    @(negedge clock);
    push_rec(16'h1234, 8'h56, 1'b0, 1'b1);
    wait_falls(5);
    check_all_idle("reset_word");
    for (int k = 1; k < fall_cyc.size(); k++)
      check_eq("reset_period", fall_cyc[k] - fall_cyc[k-1], 2 * DIV);
    check_eq("reset_ovf", overflow, 1'b0);
    reset = 1'b0;
    cap_q.delete();
    wait_falls(3);
    check_all_idle("post_reset_idle");

    // Single directed record
    cap_q.delete();
    exp_q.delete();
    expect_rec(16'hF3C2, 8'hA9, 1'b1, 1'b1);
    push_rec(16'hF3C2, 8'hA9, 1'b1, 1'b1);
    wait_falls(6);
    check_stream("single");

    // Two records in consecutive clocks: back-to-back, no idle gap
    cap_q.delete();
    exp_q.delete();
    rand_rec(1'b1);
    rand_rec(1'b1);
    wait_falls(9);
    check_stream("pair");

    // Random short bursts with random gaps
    for (int it = 0; it < 8; it++) begin
      int n;
      cap_q.delete();
      exp_q.delete();
      n = $urandom_range(1, 4);
      for (int j = 0; j < n; j++) begin
        rand_rec(1'b1);
        repeat ($urandom_range(0, 2)) @(negedge clock);
      end
      wait_falls(3 * n + 3);
      check_stream("burst");
      check_eq("burst_ovf", overflow, 1'b0);
    end

    // Overflow: align to a phi2 rise while idle, then push DEPTH+2 records in consecutive clocks
    cap_q.delete();
    exp_q.delete();
    prev_phi = gpio[10];
    budget   = 4 * DIV;
    seen     = 1'b0;
    while (budget > 0 && !seen) begin
      @(negedge clock);
      if (!prev_phi && gpio[10]) seen = 1'b1;
      prev_phi = gpio[10];
      budget--;
    end
    check_eq("ovf_align", seen, 1'b1);
    for (int j = 0; j < DEPTH + 2; j++) rand_rec(j <= DEPTH);
    check_eq("ovf_set", overflow, 1'b1);
    wait_falls(3 * (DEPTH + 1) + 3);
    check_stream("ovf_stream");
    check_eq("ovf_sticky", overflow, 1'b1);
    trace_en = 1'b0;
    @(negedge clock);
    check_eq("ovf_clear", overflow, 1'b0);

    // Pass-through while tracing is off
    user_gpio = 14'h2ABC;
    @(negedge clock);
    check_passthru("pass_2abc");
    toggles  = 0;
    prev_phi = gpio[10];
    for (int k = 0; k < 4 * DIV; k++) begin
      @(negedge clock);
      if (gpio[10] != prev_phi) toggles++;
      prev_phi = gpio[10];
    end
    check_eq("pass_phi2_toggles", toggles, 4);
    for (int k = 0; k < 3; k++) begin
      user_gpio = 14'($urandom);
      push_rec(16'($urandom), 8'($urandom), 1'b1, 1'b0);
      check_passthru("pass_rand");
    end
    trace_en = 1'b1;
    cap_q.delete();
    wait_falls(5);
    check_all_idle("pass_no_push");
    check_eq("pass_ovf", overflow, 1'b0);

    // trace_en dropped during W1 aborts the record
    cap_q.delete();
    exp_q.delete();
    rand_rec(1'b1);
    budget = 8 * DIV;
    seen   = 1'b0;
    while (budget > 0 && !seen) begin
      @(negedge clock);
      if (trace_en && gpio[11] == 1'b0 && gpio[9:8] == 2'b01) seen = 1'b1;
      budget--;
    end
    check_eq("abort_reach_w1", seen, 1'b1);
    if (cap_q.size() > 0) check_eq("abort_w0", cap_q[cap_q.size()-1], exp_q[0]);
    trace_en  = 1'b0;
    user_gpio = 14'($urandom);
    @(negedge clock);
    check_passthru("abort_pass");
    repeat (3 * DIV) @(negedge clock);
    trace_en = 1'b1;
    cap_q.delete();
    wait_falls(4);
    check_all_idle("abort_no_stale");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
